// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch front end: PC generator, imem handshake, in-order fetch queue
module fetch_queue #(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h0100_0000,
  parameter int               PC_STEP  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             imem_req_valid,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_pc,
  output logic [31:0]      out_inst,
  input  logic             out_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  // Stale responses can pile up across back-to-back redirects, so the
  // discard counter gets headroom beyond a single queue's worth.
  localparam int DISC_W = CNT_W + 4;

  logic [XLEN-1:0]   pc_mem   [DEPTH];
  logic [31:0]       inst_mem [DEPTH];
  logic [DEPTH-1:0]  filled;
  logic [PTR_W-1:0]  head, tail, fill_ptr;
  logic [CNT_W-1:0]  count;     // reserved slots, filled or not
  logic [CNT_W-1:0]  inflight;  // reserved slots still waiting for their response
  logic [DISC_W-1:0] discard;   // responses still owed for flushed requests
  logic [XLEN-1:0]   fetch_pc;

  logic              req_fire, pop, rsp_fill, rsp_drop;
  logic [DISC_W-1:0] redirect_discard;
  logic [XLEN-1:0]   redirect_target;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign imem_req_valid  = !reset && !redirect_valid && (count < CNT_W'(DEPTH));
  assign imem_req_addr   = fetch_pc;
  assign out_valid       = !reset && !redirect_valid && filled[head];
  assign out_pc          = out_valid ? pc_mem[head] : '0;
  assign out_inst        = out_valid ? inst_mem[head] : '0;

  assign req_fire        = imem_req_valid && imem_req_ready;
  assign pop             = out_valid && out_ready;
  assign rsp_drop        = imem_rsp_valid && (discard != '0);
  assign rsp_fill        = imem_rsp_valid && (discard == '0) && (inflight != '0);
  assign redirect_target = redirect_pc & ~XLEN'(3);

  // On redirect every outstanding request becomes stale; a response landing in the
  // redirect cycle itself is consumed there and so is not owed afterwards.
  always_comb begin
    redirect_discard = discard + DISC_W'(inflight);
    if (imem_rsp_valid && (redirect_discard != '0)) begin
      redirect_discard = redirect_discard - DISC_W'(1);
    end
  end

  // Queue payload storage: pc captured at request, instruction captured at fill.
  always_ff @(posedge clock) begin
    if (!reset && !redirect_valid) begin
      if (req_fire) pc_mem[tail] <= fetch_pc;
      if (rsp_fill) inst_mem[fill_ptr] <= imem_rsp_data;
    end
  end

  // Control state: pointers, occupancy, fill flags, fetch PC and discard bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      fill_ptr <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
      filled   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
      head     <= '0;
      tail     <= '0;
      fill_ptr <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= redirect_discard;
      filled   <= '0;
    end else begin
      if (req_fire) begin
        tail     <= wrap_inc(tail);
        fetch_pc <= fetch_pc + XLEN'(PC_STEP);
      end
      if (rsp_fill) begin
        filled[fill_ptr] <= 1'b1;
        fill_ptr         <= wrap_inc(fill_ptr);
      end
      if (pop) begin
        filled[head] <= 1'b0;
        head         <= wrap_inc(head);
      end
      if (rsp_drop) discard <= discard - DISC_W'(1);
      count    <= count + CNT_W'(req_fire) - CNT_W'(pop);
      inflight <= inflight + CNT_W'(req_fire) - CNT_W'(rsp_fill);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized bench for fetch_queue with queue-based reference model
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0100_0000;

  logic        clock = 0;
  logic        reset = 1;
  logic        redirect_valid = 0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 0;
  logic        imem_rsp_valid = 0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready = 0;

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .PC_STEP(4)) dut (
    .clock(clock), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] pc; logic [31:0] inst; bit filled; } slot_t;
  typedef struct { logic [31:0] data; int due; } mem_t;

  slot_t       m_q[$];
  mem_t        imem_q[$];
  logic [31:0] m_pc = RESET_PC;
  int          m_discard = 0;
  int          last_due = 0;
  int          cyc = 0;
  int          vectors = 0;
  int          errors = 0;

  int  k_rdy = 100, k_ordy = 100, k_lat_min = 1, k_lat_max = 1, k_redir = 0, k_reset_pm = 0;
  bit  f_reset = 1, f_redir = 0, k_redir_on_rsp = 0;
  logic [31:0] f_redir_pc = '0;

  logic        s_req_valid, s_out_valid, s_rsp, s_redir;
  logic [31:0] s_req_addr, s_out_pc, s_out_inst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    bit exp_rv, exp_ov, fire, pop, rsp, done;
    int unf, outst, lat, due;
    mem_t rec;
    slot_t s;
    @(negedge clock);
    reset = f_reset || ($urandom_range(999) < k_reset_pm);
    rsp = !reset && imem_q.size() > 0 && imem_q[0].due <= cyc;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? imem_q[0].data : $urandom;
    redirect_valid = f_redir || (k_redir_on_rsp && rsp) || ($urandom_range(99) < k_redir);
    if (f_redir) redirect_pc = f_redir_pc;
    else if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF4 + $urandom_range(11);
    else redirect_pc = $urandom;
    imem_req_ready = $urandom_range(99) < k_rdy;
    out_ready      = $urandom_range(99) < k_ordy;
    #1;
    exp_rv = !reset && !redirect_valid && (m_q.size() < DEPTH);
    exp_ov = !reset && !redirect_valid && m_q.size() > 0 && m_q[0].filled;
    chk("req_valid", imem_req_valid, exp_rv);
    chk("out_valid", out_valid, exp_ov);
    if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
    if (exp_ov) begin
      chk("out_pc", out_pc, m_q[0].pc);
      chk("out_inst", out_inst, m_q[0].inst);
    end
    if (reset) begin
      chk("rst_out_pc", out_pc, 32'h0);
      chk("rst_out_inst", out_inst, 32'h0);
    end
    s_req_valid = imem_req_valid; s_req_addr = imem_req_addr;
    s_out_valid = out_valid; s_out_pc = out_pc; s_out_inst = out_inst;
    s_rsp = rsp; s_redir = redirect_valid;
    fire = exp_rv && imem_req_ready;
    pop  = exp_ov && out_ready;
    if (reset) begin
      m_q.delete(); m_pc = RESET_PC; m_discard = 0;
    end else if (redirect_valid) begin
      unf = 0;
      foreach (m_q[i]) if (!m_q[i].filled) unf++;
      outst = m_discard + unf;
      if (rsp && outst > 0) outst--;
      m_discard = outst;
      m_q.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (rsp) begin
        if (m_discard > 0) m_discard--;
        else begin
          done = 0;
          for (int i = 0; i < m_q.size(); i++) begin
            if (!done && !m_q[i].filled) begin
              m_q[i].filled = 1; m_q[i].inst = imem_rsp_data; done = 1;
            end
          end
          if (!done) chk("rsp_without_slot", 32'h1, 32'h0);
        end
      end
      if (pop) void'(m_q.pop_front());
      if (fire) begin
        s.pc = m_pc; s.inst = '0; s.filled = 0;
        m_q.push_back(s);
        m_pc = m_pc + 32'd4;
      end
    end
    if (reset) begin
      imem_q.delete(); last_due = 0;
    end else begin
      if (rsp) void'(imem_q.pop_front());
      if (fire) begin
        lat = $urandom_range(k_lat_max, k_lat_min);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        rec.data = $urandom; rec.due = due;
        imem_q.push_back(rec);
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    f_reset = 1; step(); step(); f_reset = 0;
  endtask

  initial begin
    int fires;
    bit got;
    // Back-to-back fetch with single-cycle imem
    do_reset();
    step(); chk("t1_valid0", s_req_valid, 1); chk("t1_addr0", s_req_addr, 32'h0100_0000);
    step(); chk("t1_addr1", s_req_addr, 32'h0100_0004); chk("t1_ov1", s_out_valid, 0);
    step(); chk("t1_ov2", s_out_valid, 1); chk("t1_pc2", s_out_pc, 32'h0100_0000);
    step(); chk("t1_pc3", s_out_pc, 32'h0100_0004);
    repeat (10) step();

    // Decode stalled: queue fills to DEPTH and stops requesting
    do_reset();
    k_ordy = 0; fires = 0;
    repeat (8) begin step(); if (s_req_valid) fires++; end
    chk("t2_fires", fires, 4);
    chk("t2_stall", s_req_valid, 0);
    chk("t6_full_ov", s_out_valid, 1);
    k_ordy = 100; repeat (10) step();
    k_ordy = 0;   repeat (8) step();
    // Reset with a full queue
    f_reset = 1; step();
    chk("t6_rv", s_req_valid, 0); chk("t6_ov", s_out_valid, 0);
    chk("t6_pc", s_out_pc, 0); chk("t6_inst", s_out_inst, 0);
    f_reset = 0; step();
    chk("t6_rv_after", s_req_valid, 1); chk("t6_addr_after", s_req_addr, RESET_PC);
    k_ordy = 100; repeat (6) step();

    // Redirect with two requests in flight, latency 3
    k_lat_min = 3; k_lat_max = 3;
    do_reset();
    step(); step();
    f_redir = 1; f_redir_pc = 32'h0100_0203; step(); f_redir = 0;
    step(); chk("t3_rv", s_req_valid, 1); chk("t3_addr", s_req_addr, 32'h0100_0200);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!got && s_out_valid) begin got = 1; chk("t3_first_pc", s_out_pc, 32'h0100_0200); end
    end
    if (!got) chk("t3_timeout", 32'h0, 32'h1);

    // Redirect coinciding with a response while decode is ready
    k_lat_min = 2; k_lat_max = 2;
    do_reset();
    step(); step();
    k_redir_on_rsp = 1; got = 0;
    for (int i = 0; i < 6 && !got; i++) begin step(); got = s_rsp; end
    k_redir_on_rsp = 0;
    chk("t4_redir", s_redir, 1); chk("t4_ov", s_out_valid, 0);
    step(); chk("t4_empty", s_out_valid, 0);
    repeat (10) step();

    // PC wrap at the top of the address space
    k_lat_min = 1; k_lat_max = 1;
    do_reset();
    f_redir = 1; f_redir_pc = 32'hFFFF_FFFC; step(); f_redir = 0;
    step(); chk("t5_addr0", s_req_addr, 32'hFFFF_FFFC);
    step(); chk("t5_addr1", s_req_addr, 32'h0000_0000);
    repeat (8) step();

    // Randomized traffic
    k_rdy = 70; k_ordy = 60; k_lat_min = 1; k_lat_max = 3; k_redir = 3; k_reset_pm = 3;
    repeat (4000) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
